seg_scan_display: RTL

Downstream display stage for the DES text-entry/decrypt path. It captures the 64-bit decrypted block when the decrypt-done level rises and time-multiplexes it as 16 hex nibbles onto a 4-digit common-anode seven-segment display, 4 digits per page. A debounced page-step pulse moves between the 4 pages. All outputs are registered.

---
 rtl/seg_scan_display.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_display
// Purpose  : Captures a 64-bit decrypted block on the rising edge of the
//            decrypt-done level. It then time-multiplexes the block as 16 hex
//            nibbles onto a 4-digit common-anode seven-segment display. The
//            display shows 4 digits per page, and a page-step pulse cycles
//            through the 4 pages. All outputs are registered.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous active-high reset
//            valid_in  - decrypt-done level; its rising edge captures data_in
//            data_in   - [64:1] decrypted block
//            page_step - single-cycle pulse, advances the page while shown
//            seven     - segments {a..g}, active-low
//            en        - digit anodes, active-low, en[0] rightmost
//            page      - current page index
//            shown     - high while a captured block is displayed
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
  // Number of clk cycles each digit stays lit; legal range 2..65535.
  parameter int REFRESH_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [64:1]  data_in,
  input  logic         page_step,
  output logic [6:0]   seven,
  output logic [3:0]   en,
  output logic [1:0]   page,
  output logic         shown
);

  localparam logic [15:0] c_div_last = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  c_seg_off  = 7'b1111111;
  localparam logic [3:0]  c_en_off   = 4'b1111;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic        r_valid_q;
  logic [63:0] r_data_q;
  logic        r_shown;
  logic [1:0]  r_page;
  logic [15:0] r_div_cnt;
  logic [1:0]  r_digit;
  logic [6:0]  r_seven;
  logic [3:0]  r_en;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_cap;
  logic        w_div_wrap;
  logic [5:0]  w_sel;
  logic [3:0]  w_nib;
  logic [6:0]  w_hex;
  logic        w_blank;

  assign w_cap      = valid_in & ~r_valid_q;
  assign w_div_wrap = (r_div_cnt == c_div_last);

  // Bit offset of the selected nibble is 16*page + 4*digit. Port bit n maps
  // to r_data_q[n-1], so page 0 / digit 0 selects data_in[4:1].
  assign w_sel = {r_page, r_digit, 2'b00};
  assign w_nib = r_data_q[w_sel +: 4];

  // The display blanks on the same edge that samples valid_in low. The
  // display is also blank before the first registered edge after a capture,
  // which keeps the capture-to-display latency at one cycle.
  assign w_blank = ~r_shown | ~valid_in;

  always_comb begin
    w_hex = c_seg_off;
    case (w_nib)
      4'h0: w_hex = 7'b0000001;
      4'h1: w_hex = 7'b1001111;
      4'h2: w_hex = 7'b0010010;
      4'h3: w_hex = 7'b0000110;
      4'h4: w_hex = 7'b1001100;
      4'h5: w_hex = 7'b0100100;
      4'h6: w_hex = 7'b0100000;
      4'h7: w_hex = 7'b0001111;
      4'h8: w_hex = 7'b0000000;
      4'h9: w_hex = 7'b0000100;
      4'hA: w_hex = 7'b0001000;
      4'hB: w_hex = 7'b1100000;
      4'hC: w_hex = 7'b0110001;
      4'hD: w_hex = 7'b1000010;
      4'hE: w_hex = 7'b0110000;
      4'hF: w_hex = 7'b0111000;
      default: w_hex = c_seg_off;
    endcase
  end

  // --------------------------------------------------------------------------
  // Capture, invalidation and page stepping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      r_data_q  <= 64'd0;
      r_shown   <= 1'b0;
      r_page    <= 2'd0;
    end else begin
      r_valid_q <= valid_in;
      if (w_cap) begin
        // A capture overrides a coincident page step.
        r_data_q <= data_in;
        r_shown  <= 1'b1;
        r_page   <= 2'd0;
      end else if (!valid_in) begin
        r_shown  <= 1'b0;
      end else if (page_step && r_shown) begin
        r_page   <= r_page + 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Free-running digit scan
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= 16'd0;
      r_digit   <= 2'd0;
    end else if (w_div_wrap) begin
      r_div_cnt <= 16'd0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Output register: en and seven are always loaded on the same edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seven <= c_seg_off;
      r_en    <= c_en_off;
    end else if (w_blank) begin
      r_seven <= c_seg_off;
      r_en    <= c_en_off;
    end else begin
      r_seven <= w_hex;
      r_en    <= ~(4'b0001 << r_digit);
    end
  end

  assign seven = r_seven;
  assign en    = r_en;
  assign page  = r_page;
  assign shown = r_shown;

endmodule
`default_nettype wire
